// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, result/display widths and converter FSM states.
package alu_pkg;

    localparam int unsigned RESULT_W = 12;
    localparam int unsigned DIGITS   = 4;

    // One-hot ALU opcodes
    localparam logic [3:0] OP_ADD         = 4'b1000;
    localparam logic [3:0] OP_SUBTRACT    = 4'b0100;
    localparam logic [3:0] OP_MULTIPLY    = 4'b0010;
    localparam logic [3:0] OP_SHIFT_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Add 3 so the following left shift carries correctly into the next decade
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/alu_result_bcd.sv
// Iterative binary-to-BCD converter for the ALU result, one bit per cycle,
// with leading-zero blank flags for the seven-segment driver.
module alu_result_bcd #(
    parameter int unsigned RESULT_W = alu_pkg::RESULT_W,
    parameter int unsigned DIGITS   = alu_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RESULT_W-1:0]   result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(RESULT_W + 1);

    alu_pkg::state_e     state_q, state_d;
    logic [RESULT_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    bcd_adj;

    // Per-digit add-3 correction of the current BCD register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= alu_pkg::IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: capture in IDLE, adjust-then-shift in SHIFT, hold in DONE
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            alu_pkg::IDLE: begin
                if (in_valid) begin
                    bin_d   = result;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = alu_pkg::SHIFT;
                end
            end
            alu_pkg::SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[RESULT_W-1]};
                bin_d = {bin_q[RESULT_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RESULT_W - 1)) begin
                    state_d = alu_pkg::DONE;
                end
            end
            alu_pkg::DONE: begin
                if (out_ready) begin
                    state_d = alu_pkg::IDLE;
                end
            end
            default: state_d = alu_pkg::IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the registered state only
    always_comb begin
        in_ready  = (state_q == alu_pkg::IDLE);
        busy      = (state_q == alu_pkg::SHIFT);
        out_valid = (state_q == alu_pkg::DONE);
        bcd       = bcd_q;
    end

    // Leading-zero blanking; the ones digit is always shown
    always_comb begin
        logic all_zero;
        blank    = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = all_zero;
        end
    end

endmodule

// File: tb/tb_alu_result_bcd.sv
// Self-checking bench for alu_result_bcd: directed table, corner sequences,
// random traffic and a full 0..4095 sweep against a decimal reference model.
module tb_alu_result_bcd;

    localparam int unsigned RW = 12;
    localparam int unsigned DG = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] result;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   bcd;
    logic [3:0]    blank;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    alu_result_bcd #(.RESULT_W(RW), .DIGITS(DG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .blank     (blank),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] v;
        int            stall;
        int            noise;
        logic [15:0]   ebcd;
        logic [3:0]    eblank;
    } vec_t;

    // Decimal digits by plain division
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i and everything above it is zero exactly when v < 10^i
    function automatic logic [3:0] ref_blank(input int v);
        logic [3:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < 4; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // No digit may ever exceed 9 while the output is presented
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            for (int d = 0; d < 4; d++) begin
                logic [3:0] nib;
                nib = bcd[4*d +: 4];
                assert (nib <= 4'd9) else begin
                    failures++;
                    $display("FAIL digit_range digit=%0d got=%0h expected<=9", d, nib);
                end
            end
        end
    end

    // One conversion: handshake, latency, back-pressure hold, handoff.
    // noise: 0 quiet, 1 in_valid with result=12 during SHIFT, 2 random upstream noise.
    task automatic convert(input logic [RW-1:0] v, input int stall, input int noise,
                           input logic [15:0] ebcd, input logic [3:0] eblank);
        int lat;
        logic [15:0] held;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        result    = v;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (noise == 1) begin
                in_valid = 1'b1;
                result   = 12'd12;
            end else if (noise == 2) begin
                in_valid = 1'($urandom);
                result   = RW'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'd12);
        chk("bcd", 32'(bcd), 32'(ebcd));
        chk("blank", 32'(blank), 32'(eblank));
        chk("busy_in_done", 32'(busy), 32'd0);
        held = bcd;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_bcd_hold", 32'(bcd), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_out_valid", 32'(out_valid), 32'd0);
        chk("handoff_in_ready", 32'(in_ready), 32'd1);
        chk("handoff_bcd_kept", 32'(bcd), 32'(held));
    endtask

    vec_t vecs[11];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        result    = '0;

        vecs[0]  = '{12'd4095, 0,  0, 16'h4095, 4'b0000};
        vecs[1]  = '{12'd0,    0,  0, 16'h0000, 4'b1110};
        vecs[2]  = '{12'd7,    0,  0, 16'h0007, 4'b1110};
        vecs[3]  = '{12'd1000, 0,  0, 16'h1000, 4'b0000};
        vecs[4]  = '{12'd3969, 20, 0, 16'h3969, 4'b0000};
        vecs[5]  = '{12'd250,  0,  1, 16'h0250, 4'b1000};
        vecs[6]  = '{12'd12,   0,  0, 16'h0012, 4'b1100};
        vecs[7]  = '{12'd9,    0,  0, 16'h0009, 4'b1110};
        vecs[8]  = '{12'd10,   3,  0, 16'h0010, 4'b1100};
        vecs[9]  = '{12'd100,  0,  0, 16'h0100, 4'b1000};
        vecs[10] = '{12'd999,  1,  0, 16'h0999, 4'b1000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_blank", 32'(blank), 32'b1110);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            convert(vecs[i].v, vecs[i].stall, vecs[i].noise, vecs[i].ebcd, vecs[i].eblank);
        end

        // Reset in the middle of a conversion
        begin
            int ov_seen;
            in_valid = 1'b1;
            result   = 12'd3000;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            #2;
            chk("midrst_in_ready", 32'(in_ready), 32'd1);
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_bcd", 32'(bcd), 32'd0);
            chk("midrst_blank", 32'(blank), 32'b1110);
            ov_seen = 0;
            repeat (3) begin @(posedge clk); #1; if (out_valid) ov_seen = 1; end
            rst_n = 1'b1;
            repeat (20) begin @(posedge clk); #1; if (out_valid) ov_seen = 1; end
            chk("midrst_no_out_valid", 32'(ov_seen), 32'd0);
            convert(12'd99, 0, 0, 16'h0099, 4'b1100);
        end

        // Random traffic with upstream noise and random back-pressure
        for (int i = 0; i < 200; i++) begin
            int v;
            v = int'($urandom_range(4095, 0));
            convert(RW'(v), int'($urandom_range(3, 0)), 2, ref_bcd(v), ref_blank(v));
        end

        // Exhaustive sweep
        for (int v = 0; v < 4096; v++) begin
            convert(RW'(v), 0, 0, ref_bcd(v), ref_blank(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_bcd.md
# alu_result_bcd

Sequential binary-to-BCD converter sitting directly downstream of the combinational ALU. It accepts the ALU's unsigned 12-bit result through a valid/ready handshake and converts it by iterative shift-add-3 (double dabble), one bit per cycle. It then holds four packed BCD digits and per-digit leading-zero blank flags for the seven-segment display driver until they are consumed.

## Interface
Parameters:
- RESULT_W, 12, width of the binary input. Matches the ALU result width.
- DIGITS, 4, number of BCD output digits. Must satisfy 10^DIGITS > 2^RESULT_W − 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the value on result is presented.
- in_ready  output  1  block can accept a new value. Equals 1 exactly when state is IDLE.
- result  input  RESULT_W  unsigned binary value from the ALU.
- out_valid  output  1  bcd and blank hold a finished conversion.
- out_ready  input  1  consumer accepts the output.
- bcd  output  4*DIGITS  packed BCD; digit 0 (ones) is in bits [3:0].
- blank  output  DIGITS  blank[i]=1 when digit i and all higher digits are zero. blank[0] is always 0.
- busy  output  1  1 while state is SHIFT.

## Operation
- State machine states: IDLE, SHIFT, DONE.
- **IDLE**
  - On in_valid=1, capture result into the binary shift register, clear the BCD register, set count=0, and go to SHIFT.
  - On in_valid=0, stay in IDLE.
- **SHIFT**, one step per cycle:
  - First, each BCD nibble ≥5 gets +3.
  - Then shift {bcd, bin} left by 1, so the binary MSB enters bcd[0].
  - Then count increments.
  - After the step with count = RESULT_W−1, go to DONE.
- **DONE**
  - out_valid=1. bcd and blank are stable.
  - On out_ready=1, go to IDLE. bcd keeps its value after the handoff; only out_valid drops.
- in_valid outside IDLE is ignored. Upstream must hold result until the handshake completes.
- blank is combinational from the registered bcd.
- Arithmetic rules:
  - result is treated as unsigned.
  - The ALU's SUBTRACT wrap-around (e.g. 5−6 = 4095 in 12 bits) is converted as its unsigned value; no sign handling.
  - No nibble ever exceeds 9 at output. Any digit >9 is a design error and must be flagged by a bench assertion.
- Reset mid-operation:
  - Abort immediately to IDLE.
  - The partial result is discarded.
  - out_valid must not pulse.

## Timing
- Reset values:
  - state=IDLE, bcd=0, count=0.
  - out_valid=0, busy=0, in_ready=1.
  - blank = {DIGITS−1{1}},0.
- Latency:
  - Handshake accepted at edge E0.
  - Shift steps occur at edges E1..E12.
  - out_valid is high from E12 onward.
- Minimum cycle: with out_ready held at 1, state returns to IDLE at E13. in_ready is 1 in the cycle after E13. Peak throughput is one conversion per 14 cycles.
- Back-pressure: out_valid stays 1 and bcd holds unchanged for as long as out_ready=0, with no limit.
- out_ready while out_valid=0 has no effect.
- There are no combinational paths from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package alu_pkg holds:
  - the ALU opcode constants (ADD 1000 … SHIFT_RIGHT 0001);
  - RESULT_W=12 and DIGITS=4;
  - the state enum {IDLE, SHIFT, DONE}.
- Sub-module bcd_digit_adjust: a combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times.
- Top level holds the FSM, count, the shift registers and the blank logic.

## Test plan
- result=4095, out_ready=1 → out_valid at E12 with bcd=0x4095, blank=0000; in_ready=1 at E14.
- result=0 → bcd=0x0000, blank=1110. result=7 → bcd=0x0007, blank=1110. result=1000 → bcd=0x1000, blank=0000.
- result=3969 (ALU 63*63) with out_ready=0 for 20 cycles → out_valid and bcd=0x3969 stable the whole time; the single acceptance on out_ready=1 returns the block to IDLE.
- in_valid asserted with result=12 during SHIFT of result=250 → the second value is ignored and output is 0x0250. A later accepted 12 → 0x0012, blank=1100.
- rst_n low at E6 of a conversion → immediate IDLE, out_valid never rises, bcd=0. A new conversion of 99 after reset → 0x0099.
- Exhaustive sweep of 0..4095 against a reference model → every digit ≤9, and latency is exactly 12 cycles each.
